// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts simple ALU/memory/branch commands, encodes
// each into an RV32I instruction word and writes it to consecutive words of
// a 256-entry instruction memory. Flow per command: IDLE -> ENC -> WR.
// Illegal commands or a full memory park the FSM in HALT until clear_i.
module instr_encoder_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [4:0]  cmd_rd_i,
  input  logic [4:0]  cmd_rs1_i,
  input  logic [4:0]  cmd_rs2_i,
  input  logic [12:0] cmd_imm_i,
  input  logic        clear_i,
  output logic        imem_we_o,
  output logic [7:0]  imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        full_o,
  output logic        error_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2,
    S_HALT = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_BEQ = 3'd6;

  state_e      state_q;
  logic        cmd_ready_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [12:0] imm_q;
  logic [31:0] enc_q;
  logic [7:0]  ptr_q;
  logic        imem_we_q;
  logic [7:0]  imem_addr_q;
  logic [31:0] imem_wdata_q;
  logic        full_q;
  logic        error_q;

  logic [31:0] enc_d;
  logic        illegal_d;

  // Build the RV32I word for a command; illegal ops encode to zero.
  function automatic logic [31:0] encode_instr(
    input logic [2:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [12:0] imm
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    case (op)
      OP_ADD:  w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_SUB:  w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_OR:   w = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      OP_AND:  w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      OP_LW:   w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      OP_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_BEQ:  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // A command is illegal for op 7, a memory offset that does not fit in
  // 12 signed bits, or an odd branch offset.
  function automatic logic check_illegal(
    input logic [2:0]  op,
    input logic [12:0] imm
  );
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW: bad = (imm[12] != imm[11]);
      OP_BEQ:       bad = imm[0];
      3'd7:         bad = 1'b1;
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Encode and validate the latched command.
  always_comb begin
    enc_d     = encode_instr(op_q, rd_q, rs1_q, rs2_q, imm_q);
    illegal_d = check_illegal(op_q, imm_q);
  end

  // Control FSM with all outputs registered; clear_i overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      op_q         <= 3'd0;
      rd_q         <= 5'd0;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      imm_q        <= 13'd0;
      enc_q        <= 32'h0000_0000;
      ptr_q        <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 8'd0;
      imem_wdata_q <= 32'h0000_0000;
      full_q       <= 1'b0;
      error_q      <= 1'b0;
    end else if (clear_i) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      ptr_q       <= 8'd0;
      imem_we_q   <= 1'b0;
      full_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            op_q        <= cmd_op_i;
            rd_q        <= cmd_rd_i;
            rs1_q       <= cmd_rs1_i;
            rs2_q       <= cmd_rs2_i;
            imm_q       <= cmd_imm_i;
            cmd_ready_q <= 1'b0;
            state_q     <= S_ENC;
          end else begin
            // First edge after reset release raises ready here.
            cmd_ready_q <= 1'b1;
          end
        end
        S_ENC: begin
          enc_q <= enc_d;
          if (illegal_d) begin
            error_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            state_q <= S_WR;
          end
        end
        S_WR: begin
          imem_we_q    <= 1'b1;
          imem_addr_q  <= ptr_q;
          imem_wdata_q <= enc_q;
          if (ptr_q == 8'd255) begin
            // Last word written: pointer stays at 255.
            full_q  <= 1'b1;
            state_q <= S_HALT;
          end else begin
            ptr_q       <= ptr_q + 8'd1;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_HALT: begin
          cmd_ready_q <= 1'b0;
        end
        default: begin
          cmd_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign full_o       = full_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with hand-computed expected words.
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rs2;
  logic [12:0] cmd_imm;
  logic        clear;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        full;
  logic        error;

  int n_vec;
  int n_bad;

  instr_encoder_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_rd_i     (cmd_rd),
    .cmd_rs1_i    (cmd_rs1),
    .cmd_rs2_i    (cmd_rs2),
    .cmd_imm_i    (cmd_imm),
    .clear_i      (clear),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .full_o       (full),
    .error_o      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Bounded wait for cmd_ready, then one command; checks the 3-cycle flow.
  task automatic do_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm,
                        input logic exp_wr, input logic [7:0] exp_addr,
                        input logic [31:0] exp_data, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (cmd_ready === 1'b1) break;
      tick();
    end
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_busy0"}, {31'd0, cmd_ready}, 32'd0);
    tick();
    chk({tag, "_busy1"}, {31'd0, cmd_ready}, 32'd0);
    chk({tag, "_we_enc"}, {31'd0, imem_we}, 32'd0);
    tick();
    if (exp_wr) begin
      chk({tag, "_we"}, {31'd0, imem_we}, 32'd1);
      chk({tag, "_addr"}, {24'd0, imem_addr}, {24'd0, exp_addr});
      chk({tag, "_data"}, imem_wdata, exp_data);
    end else begin
      chk({tag, "_nowe"}, {31'd0, imem_we}, 32'd0);
      chk({tag, "_err"}, {31'd0, error}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] exp_w;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_rd = 5'd0; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_imm = 13'd0;
    clear = 1'b0;
    tick();
    tick();
    // Reset values
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst_data", imem_wdata, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_err", {31'd0, error}, 32'd0);
    rst_n = 1'b1;
    chk("rel_ready_pre", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("rel_ready_post", {31'd0, cmd_ready}, 32'd1);

    // Single add
    do_cmd(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 8'd0, 32'h002081B3, "add");
    tick();
    chk("we_one_cycle", {31'd0, imem_we}, 32'd0);
    chk("addr_hold", {24'd0, imem_addr}, 32'd0);
    chk("data_hold", imem_wdata, 32'h002081B3);

    // Back-to-back sub then lw, then beq with negative offset
    pulse_clear();
    do_cmd(3'd1, 5'd5, 5'd6, 5'd7, 13'd0, 1'b1, 8'd0, 32'h407302B3, "sub");
    do_cmd(3'd4, 5'd4, 5'd1, 5'd0, 13'd8, 1'b1, 8'd1, 32'h0080A203, "lw");
    do_cmd(3'd6, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1, 8'd2, 32'hFE208EE3, "beq_neg");
    do_cmd(3'd3, 5'd9, 5'd10, 5'd11, 13'd0, 1'b1, 8'd3, 32'h00B574B3, "and");
    do_cmd(3'd5, 5'd0, 5'd2, 5'd3, 13'h07FF, 1'b1, 8'd4, 32'h7E312FA3, "sw_max");

    // Odd beq offset -> error; subsequent sw ignored
    do_cmd(3'd6, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0, 8'd0, 32'd0, "beq_odd");
    cmd_op = 3'd5; cmd_imm = 13'h0800; cmd_valid = 1'b1;
    tick(); tick(); tick();
    chk("halt_ready", {31'd0, cmd_ready}, 32'd0);
    chk("halt_nowe", {31'd0, imem_we}, 32'd0);
    chk("halt_err", {31'd0, error}, 32'd1);
    cmd_valid = 1'b0;
    pulse_clear();
    chk("clr_err", {31'd0, error}, 32'd0);
    chk("clr_ready", {31'd0, cmd_ready}, 32'd1);
    do_cmd(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 8'd0, 32'h002081B3, "add_after_clr");

    // clear and cmd_valid together in IDLE: clear wins
    cmd_op = 3'd2; cmd_valid = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; cmd_valid = 1'b0;
    chk("clr_vs_valid", {31'd0, cmd_ready}, 32'd1);
    tick(); tick();
    chk("clr_vs_valid_nowe", {31'd0, imem_we}, 32'd0);
    do_cmd(3'd2, 5'd8, 5'd4, 5'd5, 13'd0, 1'b1, 8'd0, 32'h00526433, "or");

    // op 7 and out-of-range lw are illegal
    do_cmd(3'd7, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0, 8'd0, 32'd0, "op7");
    pulse_clear();
    do_cmd(3'd4, 5'd1, 5'd1, 5'd0, 13'h1000, 1'b0, 8'd0, 32'd0, "lw_range");
    pulse_clear();

    // clear during WR drops the write
    do_cmd(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 8'd0, 32'h002081B3, "add_pre");
    cmd_op = 3'd1; cmd_rd = 5'd5; cmd_rs1 = 5'd6; cmd_rs2 = 5'd7; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_wr_nowe", {31'd0, imem_we}, 32'd0);
    do_cmd(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 8'd0, 32'h002081B3, "add_ptr0");

    // Reset pulse during ENC aborts the command
    cmd_op = 3'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_enc_we", {31'd0, imem_we}, 32'd0);
    chk("rst_enc_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst_enc_data", imem_wdata, 32'd0);
    chk("rst_enc_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rst_enc_nowe", {31'd0, imem_we}, 32'd0);
    tick();
    chk("rst_enc_ready_back", {31'd0, cmd_ready}, 32'd1);
    tick();
    chk("rst_enc_still_nowe", {31'd0, imem_we}, 32'd0);

    // Fill all 256 words
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      logic [4:0] r;
      a = i[7:0];
      r = i[4:0];
      exp_w = {7'b0000000, 5'd2, 5'd1, 3'b000, r, 7'b0110011};
      do_cmd(3'd0, r, 5'd1, 5'd2, 13'd0, 1'b1, a, exp_w, "fill");
    end
    chk("full_set", {31'd0, full}, 32'd1);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_op = 3'd0; cmd_valid = 1'b1;
    tick(); tick(); tick(); tick();
    chk("full_257_nowe", {31'd0, imem_we}, 32'd0);
    chk("full_257_addr", {24'd0, imem_addr}, 32'd255);
    chk("full_hold", {31'd0, full}, 32'd1);
    cmd_valid = 1'b0;
    pulse_clear();
    chk("full_clr", {31'd0, full}, 32'd0);
    do_cmd(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 8'd0, 32'h002081B3, "add_after_full");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
